cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 MEM_WORDS, 256, depth of the unified 32-bit word memory; the address index is PC[9:2] and bits above it are ignored.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 The cpu SHALL have no other ports; program loading and result observation are done hierarchically.
REQ-005 The cpu SHALL contain a register-file instance named regf holding array regs[0:31] of 32-bit words.
REQ-006 The cpu SHALL contain a memory instance named id holding array mem[0:MEM_WORDS-1] of 32-bit words, shared by instructions and data.

Function
REQ-007 The cpu SHALL be a multi-cycle MIPS-I subset core with one ALU and registers PC, IR, MDR, A, B and ALUOut.
REQ-008 Supported instructions: add/sub/and/or/slt (opcode 0x00; funct 0x20/0x22/0x24/0x25/0x2A), addi (0x08), lw (0x23), sw (0x2B), beq (0x04), j (0x02).
REQ-009 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, ADDIEXEC, ADDIWB, BRANCH, JUMP.
REQ-010 FETCH SHALL load IR from mem[PC[9:2]] and set PC to PC+4.
REQ-011 DECODE SHALL load A=regs[rs] and B=regs[rt], and SHALL compute ALUOut=PC+(sign-extended imm<<2).
REQ-012 DECODE SHALL dispatch on opcode: lw/sw to MEMADR, R-type to RTEXEC, addi to ADDIEXEC, beq to BRANCH, j to JUMP.
REQ-013 Any other opcode SHALL return to FETCH with no architectural effect.
REQ-014 Cycle counts: lw 5, sw/R-type/addi 4, beq/j 3.
REQ-015 MEMADR SHALL compute ALUOut=A+sign-extended imm.
REQ-016 MEMRD SHALL load MDR from mem[ALUOut[9:2]]; MEMWB SHALL write MDR to regs[rt].
REQ-017 MEMWR SHALL write B to mem[ALUOut[9:2]].
REQ-018 RTEXEC SHALL compute ALUOut=A op B; RTWB SHALL write ALUOut to regs[rd].
REQ-019 For an unsupported funct, RTEXEC SHALL produce 0 and RTWB SHALL suppress the write.
REQ-020 ADDIEXEC SHALL compute A+sign-extended imm; ADDIWB SHALL write the result to regs[rt].
REQ-021 BRANCH SHALL set PC=ALUOut when A==B.
REQ-022 JUMP SHALL set PC={PC[31:28], target, 2'b00}.
REQ-023 add, sub and addi SHALL wrap modulo 2^32 with no overflow trap.
REQ-024 slt SHALL perform a signed comparison and produce 1 or 0.
REQ-025 regs[0] SHALL read as 0 at all times; writes to register 0 SHALL be discarded.
REQ-026 Memory reads SHALL be combinational; memory writes SHALL be synchronous.
REQ-027 An all-zero word SHALL execute as sll $0 (unsupported funct) with no effect, then fetch continues.
REQ-028 The memory index SHALL wrap: PC beyond the last word aliases to low addresses.

Reset
REQ-029 Asserting reset SHALL immediately force PC=0, FSM=FETCH, and IR/MDR/A/B/ALUOut=0.
REQ-030 Reset SHALL clear regs[1..31] to 0.
REQ-031 Reset SHALL NOT modify mem, so a program preloaded during reset survives.
REQ-032 Reset asserted mid-instruction SHALL abort it with no further register or memory write.
REQ-033 The first fetch SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-034 Load mem[0..2]=0x20080005, 0x2009000A, 0x01095020; hold reset 20 ns; run 500 ns at 10 ns period -> regs[8]=5, regs[9]=10, regs[10]=15, all other registers 0.
REQ-035 Program sw $t2,0x40($0) then lw $t3,0x40($0) after REQ-034 -> mem[16]=15, regs[11]=15; lw completes in exactly 5 cycles.
REQ-036 Program slt with $t0=-1 and $t1=1 -> result 1; sub 5-10 -> 0xFFFFFFFB.
REQ-037 Program beq $t0,$t0,+1 skipping an addi, and j to word 8 -> the skipped register stays 0 and PC sequence is correct; branch not taken when operands differ.
REQ-038 Program addi $0,$0,7 and an unsupported opcode (0x3F) -> regs[0]=0 and no state change; execution continues.
REQ-039 Assert reset during the MEMWR state of a sw -> memory unchanged, PC=0, and mem contents otherwise preserved.

Source files
------------

// File: rtl/cpu.sv
// Multi-cycle MIPS-I subset core with a unified word memory.
// Ports:
//   clk   - sole clock, all state updates on the rising edge
//   reset - asynchronous, active-high; clears PC, FSM, datapath regs and regs[1..31]
// Program loading and result observation are done hierarchically through
// regf.regs[] and id.mem[].
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | IR <= mem[PC], PC <= PC+4
// DECODE   | A/B <= regs[rs]/regs[rt], ALUOut <= branch target, dispatch
// MEMADR   | ALUOut <= A + sext(imm)
// MEMRD    | MDR <= mem[ALUOut]
// MEMWB    | regs[rt] <= MDR
// MEMWR    | mem[ALUOut] <= B
// RTEXEC   | ALUOut <= A op B (0 for unsupported funct)
// RTWB     | regs[rd] <= ALUOut (suppressed for unsupported funct)
// ADDIEXEC | ALUOut <= A + sext(imm)
// ADDIWB   | regs[rt] <= ALUOut
// BRANCH   | PC <= ALUOut when A == B
// JUMP     | PC <= {PC[31:28], target, 2'b00}

module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module cpu_mem #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [31:0]   wdata
);
    // No reset: a program preloaded while reset is held must survive it.
    logic [31:0] mem [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module cpu #(
    parameter int MEM_WORDS = 256
) (
    input  logic clk,
    input  logic reset
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_ZERO = 3'd5;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTEXEC, RTWB, ADDIEXEC, ADDIWB, BRANCH, JUMP
    } state_t;

    state_t      state;
    logic [31:0] pc, ir, mdr, a, b, aluout;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx;
    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_sx = {{16{ir[15]}}, ir[15:0]};

    logic [31:0] rd1, rd2;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    cpu_regfile regf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    // Single memory port: data accesses use ALUOut, everything else uses PC.
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    assign mem_addr = (state == MEMRD || state == MEMWR) ? aluout[AW+1:2] : pc[AW+1:2];
    assign mem_we   = (state == MEMWR);

    cpu_mem #(.MEM_WORDS(MEM_WORDS)) id (
        .clk   (clk),
        .addr  (mem_addr),
        .rdata (mem_rdata),
        .we    (mem_we),
        .wdata (b)
    );

    logic       funct_ok;
    logic [2:0] rt_op;
    always_comb begin
        funct_ok = 1'b1;
        rt_op    = ALU_ZERO;
        case (funct)
            6'h20:   rt_op = ALU_ADD;
            6'h22:   rt_op = ALU_SUB;
            6'h24:   rt_op = ALU_AND;
            6'h25:   rt_op = ALU_OR;
            6'h2A:   rt_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // The one ALU: operand and operation selection by state.
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_op;
    always_comb begin
        alu_a  = pc;
        alu_b  = 32'd4;
        alu_op = ALU_ADD;
        case (state)
            DECODE:           alu_b = {imm_sx[29:0], 2'b00};
            MEMADR, ADDIEXEC: begin
                alu_a = a;
                alu_b = imm_sx;
            end
            RTEXEC: begin
                alu_a  = a;
                alu_b  = b;
                alu_op = rt_op;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
    end

    // Write enables decode the current state so an asynchronous reset
    // drops them at once and aborts any pending writeback.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = aluout;
        case (state)
            MEMWB: begin
                rf_we = 1'b1;
                rf_wd = mdr;
            end
            RTWB: begin
                rf_we = funct_ok;
                rf_wa = rd;
            end
            ADDIWB: rf_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= alu_y;
                    state <= DECODE;
                end
                DECODE: begin
                    a      <= rd1;
                    b      <= rd2;
                    aluout <= alu_y;
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTEXEC;
                        OP_ADDI:      state <= ADDIEXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: begin
                    aluout <= alu_y;
                    state  <= (op == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mdr   <= mem_rdata;
                    state <= MEMWB;
                end
                RTEXEC: begin
                    aluout <= alu_y;
                    state  <= RTWB;
                end
                ADDIEXEC: begin
                    aluout <= alu_y;
                    state  <= ADDIWB;
                end
                BRANCH: begin
                    if (a == b) pc <= aluout;
                    state <= FETCH;
                end
                JUMP: begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Testbench for cpu: table of program/expectation records plus hand-written
// sequences for cycle counts, first-fetch timing and reset during a store.
module tb_cpu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          test;
        string       name;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    localparam int NTEST = 5;

    vec_t        vtab[$];
    vec_t        sb[$];
    logic [31:0] progs[0:NTEST-1][0:11];
    int          applied = 0;
    int          miscompares = 0;

    function automatic void addv(int t, string n, bit m, int i, logic [31:0] e);
        vec_t v;
        v.test = t; v.name = n; v.is_mem = m; v.idx = i; v.exp = e;
        vtab.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_prog(input int t);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.id.mem[i] = 32'h0;
        for (int i = 0; i < 12; i++) dut.id.mem[i] = progs[t][i];
        @(negedge clk);
    endtask

    // Wait for PC to show p (just after the fetch of an instruction), then
    // count edges until PC moves on: that is the instruction's cycle count.
    task automatic measure(input logic [31:0] p, input int exp, input string name);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (dut.pc !== p && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_reach"}, dut.pc, p);
        while (dut.pc === p && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int t = 0; t < NTEST; t++)
            for (int i = 0; i < 12; i++) progs[t][i] = 32'h0;

        // T0: addi/addi/add, then sw $t2,0x40($0); lw $t3,0x40($0)
        progs[0][0] = 32'h20080005; progs[0][1] = 32'h2009000A;
        progs[0][2] = 32'h01095020; progs[0][3] = 32'hAC0A0040;
        progs[0][4] = 32'h8C0B0040;
        // T1: ALU ops incl. signed slt, sub/add/addi wrap
        progs[1][0]  = 32'h2008FFFF; progs[1][1]  = 32'h20090001;
        progs[1][2]  = 32'h0109502A; progs[1][3]  = 32'h200B0005;
        progs[1][4]  = 32'h200C000A; progs[1][5]  = 32'h016C6822;
        progs[1][6]  = 32'h0128702A; progs[1][7]  = 32'h01097824;
        progs[1][8]  = 32'h016C8025; progs[1][9]  = 32'h21120002;
        progs[1][10] = 32'h01088820;
        // T2: taken beq skips word 3, untaken beq, j 8 skips word 7, j-self at 9
        progs[2][0] = 32'h20080003; progs[2][1] = 32'h20090004;
        progs[2][2] = 32'h11080001; progs[2][3] = 32'h200A0007;
        progs[2][4] = 32'h11090001; progs[2][5] = 32'h200B0007;
        progs[2][6] = 32'h08000008; progs[2][7] = 32'h200C0007;
        progs[2][8] = 32'h200D0009; progs[2][9] = 32'h08000009;
        // T3: addi $0, opcode 0x3F, all-zero word, then continue
        progs[3][0] = 32'h20000007; progs[3][1] = 32'hFC000000;
        progs[3][2] = 32'h00000000; progs[3][3] = 32'h20080001;
        progs[3][4] = 32'h08000004;
        // T4: jump to word 0x105 aliases to word 5
        progs[4][0] = 32'h08000105; progs[4][1] = 32'h20090001;
        progs[4][5] = 32'h20080011; progs[4][6] = 32'h08000106;

        addv(0, "base_r8", 0, 8, 32'd5);       addv(0, "base_r9", 0, 9, 32'd10);
        addv(0, "base_r10", 0, 10, 32'd15);    addv(0, "lw_r11", 0, 11, 32'd15);
        addv(0, "sw_mem16", 1, 16, 32'd15);    addv(0, "base_r1", 0, 1, 32'd0);
        addv(0, "base_r12", 0, 12, 32'd0);     addv(0, "base_r31", 0, 31, 32'd0);
        addv(1, "slt_neg", 0, 10, 32'd1);      addv(1, "sub_wrap", 0, 13, 32'hFFFFFFFB);
        addv(1, "slt_false", 0, 14, 32'd0);    addv(1, "and", 0, 15, 32'd1);
        addv(1, "or", 0, 16, 32'd15);          addv(1, "add_neg", 0, 17, 32'hFFFFFFFE);
        addv(1, "addi_wrap", 0, 18, 32'd1);
        addv(2, "br_r8", 0, 8, 32'd3);         addv(2, "br_r9", 0, 9, 32'd4);
        addv(2, "beq_skip", 0, 10, 32'd0);     addv(2, "beq_nt", 0, 11, 32'd7);
        addv(2, "j_skip", 0, 12, 32'd0);       addv(2, "j_target", 0, 13, 32'd9);
        addv(3, "r0_zero", 0, 0, 32'd0);       addv(3, "cont_r8", 0, 8, 32'd1);
        addv(3, "mem1_kept", 1, 1, 32'hFC000000);
        addv(3, "mem0_kept", 1, 0, 32'h20000007);
        addv(3, "nop_r1", 0, 1, 32'd0);
        addv(4, "alias_r8", 0, 8, 32'h11);     addv(4, "alias_skip", 0, 9, 32'd0);

        // Reset state
        @(posedge clk); #1;
        check("rst_pc", dut.pc, 32'h0);
        check("rst_ir", dut.ir, 32'h0);
        check("rst_aluout", dut.aluout, 32'h0);
        check("rst_mdr", dut.mdr, 32'h0);

        for (int t = 0; t < NTEST; t++) begin
            load_prog(t);
            foreach (vtab[k]) if (vtab[k].test == t) sb.push_back(vtab[k]);
            reset = 1'b0;
            repeat (80) @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                vec_t v;
                logic [31:0] act;
                v = sb.pop_front();
                act = v.is_mem ? dut.id.mem[v.idx] : dut.regf.regs[v.idx];
                check(v.name, act, v.exp);
            end
        end

        // First fetch on first edge after reset release, then cycle counts
        load_prog(0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("first_fetch_pc", dut.pc, 32'd4);
        check("first_fetch_ir", dut.ir, 32'h20080005);
        measure(32'd12, 4, "add_cycles");
        measure(32'd16, 4, "sw_cycles");
        measure(32'd20, 5, "lw_cycles");

        // Reset asserted while a store sits in MEMWR
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.id.mem[i] = 32'h0;
        dut.id.mem[0]  = 32'h20080055;
        dut.id.mem[1]  = 32'hAC080040;
        dut.id.mem[16] = 32'h12345678;
        @(negedge clk);
        reset = 1'b0;
        begin
            int guard;
            guard = 0;
            while (dut.pc !== 32'd8 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        check("sw_fetched_pc", dut.pc, 32'd8);
        @(posedge clk);
        @(posedge clk); #1;
        check("memwr_addr", dut.aluout, 32'h40);
        check("memwr_r8", dut.regf.regs[8], 32'h55);
        reset = 1'b1;
        #1;
        check("abort_pc", dut.pc, 32'h0);
        check("abort_b", dut.b, 32'h0);
        check("abort_r8", dut.regf.regs[8], 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_mem16", dut.id.mem[16], 32'h12345678);
        check("abort_mem0", dut.id.mem[0], 32'h20080055);
        check("abort_mem1", dut.id.mem[1], 32'hAC080040);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("refetch_pc", dut.pc, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
